// File: rtl/ram_bit_serializer_ctrl_pkg.sv
// Shared types and width defaults for the RAM word bit serializer.
package ram_bit_serializer_ctrl_pkg;

  localparam int unsigned DEFAULT_INPUT_WIDTH = 16;
  localparam int unsigned DEFAULT_REG_WIDTH   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    ASC  = 1'b0,
    DESC = 1'b1
  } dir_t;

endpackage

// File: rtl/ram_bit_serializer_ctrl_if.sv
// Word-in / bit-out handshake bundle for the serializer.
interface ram_bit_serializer_ctrl_if
  import ram_bit_serializer_ctrl_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = DEFAULT_INPUT_WIDTH,
  parameter int unsigned REG_WIDTH   = DEFAULT_REG_WIDTH
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INPUT_WIDTH-1:0] in_data;
  logic [REG_WIDTH-1:0]   in_start_bit;
  logic [REG_WIDTH-1:0]   in_end_bit;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_bit;
  logic [REG_WIDTH-1:0]   out_idx;
  logic                   out_last;

  modport master (
    output in_valid, in_data, in_start_bit, in_end_bit, out_ready,
    input  in_ready, out_valid, out_bit, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, in_start_bit, in_end_bit, out_ready,
    output in_ready, out_valid, out_bit, out_idx, out_last
  );
endinterface

// File: rtl/ram_bit_serializer_ctrl_bit_select_mux_16.sv
// Purely combinational 16:1 bit selector.
module bit_select_mux_16 (
  input  logic [15:0] word,
  input  logic [3:0]  idx,
  output logic        bit_out
);
  always_comb begin
    bit_out = word[idx];
  end
endmodule

// File: rtl/ram_bit_serializer_ctrl.sv
// Latches a word and emits a start..end bit range, one bit per transfer,
// in either direction; counts completed words.
module ram_bit_serializer_ctrl
  import ram_bit_serializer_ctrl_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = DEFAULT_INPUT_WIDTH,
  parameter int unsigned REG_WIDTH   = DEFAULT_REG_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  ram_bit_serializer_ctrl_if.slave bus,
  output logic [7:0]               words_done
);

  state_t                 state;
  state_t                 state_nxt;
  dir_t                   dir;
  logic [INPUT_WIDTH-1:0] word;
  logic [REG_WIDTH-1:0]   idx;
  logic [REG_WIDTH-1:0]   end_idx;
  logic                   sel_bit;
  logic                   accept;
  logic                   transfer;
  logic                   last;

  // Handshakes decode from registered state only, never from outputs.
  assign accept   = bus.in_valid && (state == IDLE);
  assign transfer = bus.out_ready && (state == RUN);
  assign last     = (idx == end_idx);

  bit_select_mux_16 u_mux (
    .word    (word),
    .idx     (idx),
    .bit_out (sel_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (transfer && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_bit   = 1'b0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    case (state)
      IDLE: bus.in_ready = 1'b1;
      RUN: begin
        bus.out_valid = 1'b1;
        bus.out_bit   = sel_bit;
        bus.out_idx   = idx;
        bus.out_last  = last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word    <= '0;
      idx     <= '0;
      end_idx <= '0;
      dir     <= ASC;
    end else if (accept) begin
      word    <= bus.in_data;
      idx     <= bus.in_start_bit;
      end_idx <= bus.in_end_bit;
      dir     <= (bus.in_start_bit <= bus.in_end_bit) ? ASC : DESC;
    end else if (transfer && !last) begin
      idx <= (dir == ASC) ? idx + 1'b1 : idx - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_done <= '0;
    end else if (transfer && last) begin
      words_done <= words_done + 8'd1;
    end
  end

endmodule

// File: tb/tb_ram_bit_serializer_ctrl.sv
// Directed bench for ram_bit_serializer_ctrl with hand-computed bit sequences.
module tb_ram_bit_serializer_ctrl;
  import ram_bit_serializer_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  words_done;
  int unsigned checks = 0;
  int unsigned errors = 0;

  ram_bit_serializer_ctrl_if #(.INPUT_WIDTH(16), .REG_WIDTH(4)) bus ();

  ram_bit_serializer_ctrl #(.INPUT_WIDTH(16), .REG_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .words_done (words_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] data, input logic [3:0] s, input logic [3:0] e);
    bus.in_valid     = 1'b1;
    bus.in_data      = data;
    bus.in_start_bit = s;
    bus.in_end_bit   = e;
    tick();
    bus.in_valid     = 1'b0;
  endtask

  task automatic check_bit(input string tag, input logic b, input int unsigned i, input logic l);
    check_eq({tag, "_valid"}, int'(bus.out_valid), 1);
    check_eq({tag, "_ready"}, int'(bus.in_ready), 0);
    check_eq({tag, "_bit"},   int'(bus.out_bit), int'(b));
    check_eq({tag, "_idx"},   int'(bus.out_idx), i);
    check_eq({tag, "_last"},  int'(bus.out_last), int'(l));
  endtask

  // bits[k] is the k-th emitted bit; stall_at >= n means no stall.
  task automatic expect_word(input string tag, input logic [15:0] bits, input int unsigned n,
                             input int unsigned start, input bit desc, input int unsigned stall_at);
    int unsigned exp_idx;
    for (int unsigned k = 0; k < n; k++) begin
      exp_idx = desc ? start - k : start + k;
      check_bit(tag, bits[k], exp_idx, k == n - 1);
      if (k == stall_at) begin
        bus.out_ready = 1'b0;
        for (int unsigned s = 0; s < 2; s++) begin
          bus.in_valid = 1'b1;
          bus.in_data  = 16'h5A3C ^ 16'(s);
          tick();
          check_bit({tag, "_stall"}, bits[k], exp_idx, k == n - 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
      tick();
    end
    check_eq({tag, "_end_valid"}, int'(bus.out_valid), 0);
    check_eq({tag, "_end_ready"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_start_bit = '0;
    bus.in_end_bit   = '0;
    bus.out_ready    = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check_eq("rst_ready", int'(bus.in_ready), 1);
    check_eq("rst_valid", int'(bus.out_valid), 0);
    check_eq("rst_bit",   int'(bus.out_bit), 0);
    check_eq("rst_idx",   int'(bus.out_idx), 0);
    check_eq("rst_last",  int'(bus.out_last), 0);
    check_eq("rst_words", int'(words_done), 0);

    // A5C3 ascending 0..15: emitted order equals the word LSB-first.
    send_word(16'hA5C3, 4'd0, 4'd15);
    expect_word("asc", 16'b1010_0101_1100_0011, 16, 0, 1'b0, 99);
    check_eq("asc_words", int'(words_done), 1);

    // 00F0 descending 7..4: four ones.
    send_word(16'h00F0, 4'd7, 4'd4);
    expect_word("desc", 16'h000F, 4, 7, 1'b1, 99);
    check_eq("desc_words", int'(words_done), 2);

    // Single bit 9; a competing word offered during the last transfer must be ignored.
    send_word(16'h0200, 4'd9, 4'd9);
    check_bit("single", 1'b1, 9, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    tick();
    bus.in_valid = 1'b0;
    check_eq("single_end_valid", int'(bus.out_valid), 0);
    check_eq("single_end_ready", int'(bus.in_ready), 1);
    check_eq("single_words", int'(words_done), 3);

    // Backpressure: ready 1,0,0,1 around the third bit, in_data scrambled meanwhile.
    send_word(16'hA5C3, 4'd0, 4'd15);
    expect_word("bp", 16'b1010_0101_1100_0011, 16, 0, 1'b0, 2);
    check_eq("bp_words", int'(words_done), 4);

    // Reset after five transfers.
    send_word(16'hA5C3, 4'd0, 4'd15);
    for (int unsigned k = 0; k < 5; k++) begin
      check_eq("mid_idx", int'(bus.out_idx), k);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_valid", int'(bus.out_valid), 0);
    check_eq("mid_ready", int'(bus.in_ready), 1);
    check_eq("mid_words", int'(words_done), 0);
    tick();
    check_eq("mid_hold_valid", int'(bus.out_valid), 0);
    check_eq("mid_hold_words", int'(words_done), 0);
    send_word(16'h00F0, 4'd7, 4'd4);
    expect_word("post", 16'h000F, 4, 7, 1'b1, 99);
    check_eq("post_words", int'(words_done), 1);

    // Counter wrap over 256 single-bit words at rotating positions.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int unsigned i = 1; i <= 256; i++) begin
      send_word(16'h0001 << (i % 16), 4'(i % 16), 4'(i % 16));
      check_eq("wrap_bit", int'(bus.out_bit), 1);
      tick();
      check_eq("wrap_words", int'(words_done), i % 256);
    end
    check_eq("wrap_zero", int'(words_done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bit_serializer_ctrl.md
RAM_BIT_SERIALIZER_CTRL -- requirements
Module: ram_bit_serializer_ctrl

Interface
REQ-001 Parameter INPUT_WIDTH, default 16, word width in bits; only 16 is supported.
REQ-002 Parameter REG_WIDTH, default 4, bit-index width (log2 of INPUT_WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream word offered.
REQ-006 in_ready  output  1  controller can accept a word.
REQ-007 in_data  input  INPUT_WIDTH  word to serialize.
REQ-008 in_start_bit  input  REG_WIDTH  first bit index, sampled with in_data.
REQ-009 in_end_bit  input  REG_WIDTH  last bit index, sampled with in_data.
REQ-010 out_valid  output  1  out_bit is presented.
REQ-011 out_ready  input  1  downstream consumes out_bit.
REQ-012 out_bit  output  1  selected bit of the latched word.
REQ-013 out_idx  output  REG_WIDTH  index of out_bit.
REQ-014 out_last  output  1  out_bit is the final bit of the word.
REQ-015 words_done  output  8  count of completed words, wraps 255->0.

Function
REQ-016 FSM states: IDLE and RUN.
REQ-017 In IDLE, in_ready = 1, out_valid = 0, and out_bit, out_idx and out_last = 0.
REQ-018 Accept = in_valid && in_ready: latch in_data, idx <= in_start_bit, end <= in_end_bit, dir <= ascending if start <= end else descending; next state RUN.
REQ-019 In RUN, in_ready = 0, out_valid = 1, out_bit = word[idx], out_idx = idx, out_last = (idx == end).
REQ-020 Latency: accept at edge N; first bit valid in the cycle after edge N.
REQ-021 Throughput: one bit per cycle while out_ready = 1.
REQ-022 Transfer = out_valid && out_ready; if not last, idx steps +1 when ascending and -1 when descending.
REQ-023 Transfer with out_last = 1 returns to IDLE and increments words_done by 1.
REQ-024 Stall: while out_ready = 0 in RUN, out_bit, out_idx, out_last and the internal state are held unchanged.
REQ-025 Bits emitted per word = |end - start| + 1, from 1 (start == end) to 16 (0..15 or 15..0).
REQ-026 idx never wraps; the sequence ends exactly at end.
REQ-027 in_data, in_start_bit and in_end_bit are ignored outside the accept cycle.
REQ-028 A new word is not accepted in the same cycle as a last transfer; in_ready rises the cycle after.
REQ-029 All outputs are registered or decoded from registered state only; there is no combinational path from in_* or out_ready to any output.

Reset
REQ-030 rst = 1 at a rising edge forces IDLE, clears the latched word, idx, end and dir, and sets words_done = 0.
REQ-031 rst asserted mid-word aborts the word without a further out_valid, and words_done is not incremented.
REQ-032 rst has priority over accept and transfer in the same cycle.

Structure
REQ-033 A shared package holds the INPUT_WIDTH and REG_WIDTH defaults, the FSM state typedef {IDLE, RUN}, and the direction enum {ASC, DESC}.
REQ-034 Bit selection is implemented in one combinational sub-module, bit_select_mux_16: 16-bit word plus 4-bit index in, 1 bit out.
REQ-035 Index stepping, FSM and words_done counter reside in ram_bit_serializer_ctrl.

Verification
REQ-036 Ascending: in_data = 16'hA5C3, start = 0, end = 15, out_ready = 1 -> 16 bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on consecutive cycles; out_last only at idx 15; words_done = 1.
REQ-037 Descending subrange: in_data = 16'h00F0, start = 7, end = 4 -> bits 1,1,1,1 at idx 7,6,5,4; out_last at idx 4; back to IDLE.
REQ-038 Single bit: start = end = 9, in_data = 16'h0200 -> one cycle with out_bit = 1, out_last = 1; in_ready high the next cycle.
REQ-039 Backpressure: out_ready toggles 1,0,0,1 during the 16'hA5C3 word -> outputs held stable for 2 cycles; sequence identical to REQ-036; changing in_data mid-word has no effect.
REQ-040 Reset mid-word: rst pulsed after 5 transfers -> the next cycle has out_valid = 0 and in_ready = 1, words_done = 0; a following word serializes correctly.
REQ-041 Counter wrap: 256 single-bit words -> words_done reads 255 and then 0.
